pixel_fb_writer: RTL
====================

# pixel_fb_writer

Framebuffer write-back stage that consumes the pixel stream from the shape generators (rectangle, line, etc.) and writes it into framebuffer memory. It clips out-of-bounds pixels, converts 24-bit RGB888 to RGB565, computes linear addresses, and buffers pixels in a FIFO because the generators have no backpressure. It then issues one memory write per pixel over a req/ack handshake and pulses `frame_done` once the generator's `done` has arrived and every accepted pixel has been written.

## Interface
Parameters:
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `ADDR_W`, 15: memory address width. Must satisfy FB_W*FB_H ≤ 2^ADDR_W.
- `FIFO_DEPTH`, 16: pixel FIFO entries, power of 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `px`  in  8  pixel x.
- `py`  in  8  pixel y.
- `pixel_color`  in  24  RGB888, {R,G,B}.
- `pixel_valid`  in  1  pixel present this cycle.
- `draw_done`  in  1  generator completion pulse.
- `clear`  in  1  synchronous clear of `overflow` and `clip_count`.
- `mem_req`  out  1  write request.
- `mem_addr`  out  ADDR_W  linear address.
- `mem_wdata`  out  16  RGB565 data.
- `mem_ack`  in  1  write accepted this cycle.
- `busy`  out  1  work outstanding.
- `frame_done`  out  1  one-cycle completion pulse.
- `overflow`  out  1  sticky; set when a pixel was dropped because the FIFO was full.
- `clip_count`  out  16  saturating count of clipped pixels.

## Operation
- Input stage, on each cycle with `pixel_valid`=1:
  - If px ≥ FB_W or py ≥ FB_H: drop the pixel; `clip_count` += 1, saturating at 0xFFFF.
  - Otherwise push {addr, data}, where addr = py*FB_W + px (computed at 16 bits, truncated to ADDR_W) and data = {R[7:3], G[7:2], B[7:3]}.
- FIFO full at push:
  - If the FSM pops in the same cycle, the push is accepted.
  - Otherwise the pixel is dropped and `overflow` is set.
- `draw_done`=1 sets the internal `done_pending` flag. If it is already set, there is no further effect. A pixel and `draw_done` in the same cycle are both recorded.
- FSM states and transitions:
  - IDLE:
    - FIFO non-empty: load head into the mem_addr/mem_wdata registers, pop, set mem_req=1, go to WRITE.
    - FIFO empty and `done_pending`: go to FINISH.
  - WRITE: hold mem_req, mem_addr and mem_wdata stable until `mem_ack`=1 is sampled. On ack:
    - FIFO non-empty: load next entry, pop, stay in WRITE with mem_req=1 (back-to-back).
    - FIFO empty: mem_req=0, go to IDLE.
  - FINISH: `frame_done`=1 for this single cycle, clear `done_pending`, go to IDLE.
- `busy` = (state≠IDLE) | FIFO non-empty | done_pending.
- `clear` wins over a same-cycle overflow or clip event; that event is not counted.

## Timing
- Reset value of every output is 0: mem_req, mem_addr, mem_wdata, busy, frame_done, overflow, clip_count. FIFO is emptied, `done_pending`=0, state=IDLE.
- Reset mid-write abandons the in-flight write and drops `mem_req` immediately (asynchronous).
- Latency: a pixel sampled at edge k with the FSM in IDLE drives mem_req=1 and its addr/data after edge k+1.
- Throughput: with `mem_ack` tied high, one write per cycle.
- `mem_ack` is ignored while mem_req=0.
- `frame_done` asserts at the earliest one cycle after the final ack. A frame with zero valid pixels still produces one `frame_done`.
- Total buffering is FIFO_DEPTH + 1 pixels (FIFO plus the output register).

## Structure
- Shared package `gfx_pkg` holds:
  - default FB_W and FB_H;
  - function `rgb888_to_565`;
  - FSM state encoding (IDLE, WRITE, FINISH).
- One sub-module, `pixel_fifo`: a synchronous FIFO with parameterized width and depth, outputs full/empty, and a show-ahead head.

## Test plan
- Single pixel (3,2), color 0xFF8040, ack tied 1 -> one write, addr 323, wdata 0xFC08. Then `draw_done` -> `frame_done` pulses once; `busy` returns to 0.
- Pixels (200,5) and (10,130) -> no mem_req, clip_count=2. Then `clear` -> clip_count=0.
- Ack held 0, 18 consecutive valid in-range pixels -> 17 accepted, overflow=1. Release ack -> exactly 17 writes in input order.
- 4x3 rectangle stream from (0,0), ack tied 1 -> 12 writes in consecutive cycles (addrs 0-3, 160-163, 320-323). `frame_done` follows the last ack.
- Ack asserted every 3rd cycle -> mem_addr/mem_wdata stable while mem_req high and unacked; no loss or duplication.
- `rst` during WRITE with 5 queued pixels -> mem_req drops immediately, FIFO empty, busy=0. A subsequent frame completes normally.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics definitions: default framebuffer geometry, colour conversion
// and the write-back FSM state encoding.
package gfx_pkg;

    localparam int FB_W_DEFAULT = 160;
    localparam int FB_H_DEFAULT = 120;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } fb_state_t;

    function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only if a pop
// happens in the same cycle.
module pixel_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_fb_writer.sv
// Framebuffer write-back: clips, converts RGB888->RGB565, buffers pixels and
// writes them to memory over a req/ack handshake, then signals frame completion.
module pixel_fb_writer
    import gfx_pkg::*;
#(
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        px,
    input  logic [7:0]        py,
    input  logic [23:0]       pixel_color,
    input  logic              pixel_valid,
    input  logic              draw_done,
    input  logic              clear,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       clip_count
);

    localparam int ENTRY_W = ADDR_W + 16;

    fb_state_t          state;
    fb_state_t          state_next;
    logic               in_range;
    logic [ADDR_W-1:0]  lin_addr;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_req;
    logic               pop;
    logic               load;
    logic               drop;
    logic               clip_hit;
    logic               done_pending;

    assign in_range   = ({24'd0, px} < FB_W) && ({24'd0, py} < FB_H);
    assign lin_addr   = ADDR_W'(16'(py) * 16'(FB_W) + 16'(px));
    assign push_entry = {lin_addr, rgb888_to_565(pixel_color)};
    assign push_req   = pixel_valid && in_range;
    assign clip_hit   = pixel_valid && !in_range;
    // A full FIFO still takes the pixel when the FSM pops in the same cycle.
    assign drop       = push_req && fifo_full && !pop;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = ST_WRITE;
                end else if (done_pending) begin
                    state_next = ST_FINISH;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load) begin
            {mem_addr, mem_wdata} <= head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow     <= 1'b0;
            clip_count   <= '0;
            done_pending <= 1'b0;
        end else begin
            if (clear) begin
                overflow   <= 1'b0;
                clip_count <= '0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (clip_hit && (clip_count != '1)) clip_count <= clip_count + 1'b1;
            end
            if (state == ST_FINISH) begin
                done_pending <= 1'b0;
            end else if (draw_done) begin
                done_pending <= 1'b1;
            end
        end
    end

    // mem_req decodes straight from the state flop so reset drops it at once.
    assign mem_req    = (state == ST_WRITE);
    assign frame_done = (state == ST_FINISH);
    assign busy       = (state != ST_IDLE) || !fifo_empty || done_pending;

endmodule
